carregador_programa: RTL and testbench
======================================

Name: carregador_programa

Overview:
- Program loader that sits directly upstream of the NRISC processor and its instruction memory.
- Accepts a framed byte stream (start address, length, payload, checksum) on a valid/ready interface and writes the payload into instruction memory.
- On a good checksum, sets the initial PC and releases the processor's reset.
- Watches the fetched instruction for the HALT opcode, stops the processor and reports completion.

Parameters:
HALT_OPCODE, 8'b11000000, instruction value that ends execution
TIMEOUT, 255, max idle cycles between bytes inside a frame before abort (1..255)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
DadoEntrada  input  8  stream byte
EntradaValida  input  1  stream byte valid
EntradaPronta  output  1  loader ready; a byte is accepted when EntradaValida && EntradaPronta
EscreverInstr  output  1  one-cycle write strobe to instruction memory
EnderecoInstr  output  8  instruction-memory write address
DadoInstr  output  8  instruction-memory write data
ResetCPU  output  1  active-low reset to the processor; 0 = held in reset
PCInicial  output  8  start PC presented to the processor while ResetCPU=0
Instrucao  input  8  instruction currently fetched by the processor
Parado  output  1  sticky: HALT seen
Erro  output  1  sticky: checksum, zero-length or timeout error

Behaviour:
- Reset (reset=0, async): state=OCIOSO; EntradaPronta=0, EscreverInstr=0, EnderecoInstr=0, DadoInstr=0, ResetCPU=0, PCInicial=0, Parado=0, Erro=0; counters and sum cleared.
- States: OCIOSO, TAMANHO, DADOS, SOMA, EXECUTA.
- EntradaPronta=1 in OCIOSO, TAMANHO, DADOS and SOMA; 0 in EXECUTA and during reset.
- OCIOSO, byte accepted:
  - Byte -> base address register.
  - Parado and Erro cleared.
  - Go to TAMANHO.
- TAMANHO, byte accepted:
  - Byte = 0: Erro=1, back to OCIOSO.
  - Otherwise: byte -> remaining count N, write pointer = base, sum=0, go to DADOS.
- DADOS, each accepted byte:
  - Next cycle: EscreverInstr=1 for exactly one cycle, EnderecoInstr=pointer, DadoInstr=byte (1-cycle latency).
  - Pointer increments mod 256 (255 wraps to 0); sum += byte mod 256; N decrements.
  - N reaching 0 -> SOMA.
- SOMA, byte accepted:
  - (sum + byte) mod 256 == 0: PCInicial=base; ResetCPU=1 starting the next cycle; go to EXECUTA.
  - Otherwise: Erro=1, ResetCPU stays 0, back to OCIOSO. Bytes already written are not undone.
- Timeout:
  - Applies in TAMANHO, DADOS and SOMA.
  - Idle counter resets on every accepted byte and increments each cycle with no accept.
  - Reaching TIMEOUT: Erro=1, back to OCIOSO, no further writes.
  - No timeout in OCIOSO.
- EXECUTA:
  - Instrucao is sampled every cycle.
  - Instrucao == HALT_OPCODE: Parado=1, ResetCPU=0 the next cycle, go to OCIOSO.
  - PCInicial holds its value.
  - EntradaValida is ignored (EntradaPronta=0).
- Parado and Erro stay set until the first byte of the next frame is accepted, or until reset.
- EscreverInstr is never asserted outside the cycle after a DADOS accept.
- Back-to-back accepts, one byte per cycle, are supported with no bubbles.
- Reset asserted mid-frame or mid-execution: immediate return to the reset values; a partially written program is left in memory.

Test Plan:
- Good load: frame 14,03,E0,0F,C0,51 (hex) sent back-to-back -> three write strobes: addr 14/E0, 15/0F, 16/C0. ResetCPU rises the cycle after the 51 is accepted; PCInicial=14; Erro=0.
- HALT: continuing the good-load case, drive Instrucao=E0 then C0 -> Parado=1 and ResetCPU=0 one cycle after C0 is seen; EntradaPronta returns to 1.
- Bad checksum: frame 14,03,E0,0F,C0,50 -> three writes occur, Erro=1, ResetCPU stays 0, state OCIOSO. A following good frame clears Erro on its first byte.
- Zero length and wrap: frame 05,00 -> Erro=1 with no writes. Frame FE,03,01,02,03,FA -> writes to addr FE, FF, 00; load succeeds with PCInicial=FE.
- Timeout and throttling: 14,02,AA, then EntradaValida held low for 255 cycles -> Erro=1 and exactly one write. Separately, with valid toggled every other cycle on a good frame, one write per accepted byte and no timeout.
- Async reset mid-DADOS: reset pulsed low between clock edges -> all outputs return to their reset values immediately; no strobe occurs after the reset edge.

Source files
------------

// File: rtl/carregador_programa.sv
// carregador_programa: framed byte-stream program loader that fills instruction memory, starts the CPU and stops it on HALT.
module carregador_programa #(
  parameter logic [7:0] HALT_OPCODE = 8'b1100_0000,
  parameter int         TIMEOUT     = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] DadoEntrada,
  input  logic       EntradaValida,
  output logic       EntradaPronta,
  output logic       EscreverInstr,
  output logic [7:0] EnderecoInstr,
  output logic [7:0] DadoInstr,
  output logic       ResetCPU,
  output logic [7:0] PCInicial,
  input  logic [7:0] Instrucao,
  output logic       Parado,
  output logic       Erro
);
  typedef enum logic [2:0] {OCIOSO, TAMANHO, DADOS, SOMA, EXECUTA} estado_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  estado_t    state_q, state_d;
  logic [7:0] base_q, base_d, cnt_q, cnt_d, ptr_q, ptr_d, sum_q, sum_d, idle_q, idle_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, pc_q, pc_d;
  logic       wr_q, wr_d, rcpu_q, rcpu_d, parado_q, parado_d, erro_q, erro_d, pronta_q, pronta_d;
  logic       aceita;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    idle_d   = idle_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    rcpu_d   = rcpu_q;
    pc_d     = pc_q;
    parado_d = parado_q;
    erro_d   = erro_q;
    aceita   = EntradaValida && pronta_q;
    // inter-byte watchdog; any accept in the same cycle overrides the abort below
    if (state_q inside {TAMANHO, DADOS, SOMA}) begin
      idle_d = aceita ? 8'd0 : idle_q + 8'd1;
      if (!aceita && idle_q == TO_LAST) begin
        erro_d  = 1'b1;
        state_d = OCIOSO;
        idle_d  = 8'd0;
      end
    end
    case (state_q)
      OCIOSO: if (aceita) begin
        base_d   = DadoEntrada;
        parado_d = 1'b0;
        erro_d   = 1'b0;
        idle_d   = 8'd0;
        state_d  = TAMANHO;
      end
      TAMANHO: if (aceita) begin
        if (DadoEntrada == 8'd0) begin
          erro_d  = 1'b1;
          state_d = OCIOSO;
        end else begin
          cnt_d   = DadoEntrada;
          ptr_d   = base_q;
          sum_d   = 8'd0;
          state_d = DADOS;
        end
      end
      DADOS: if (aceita) begin
        wr_d   = 1'b1;
        addr_d = ptr_q;
        data_d = DadoEntrada;
        ptr_d  = ptr_q + 8'd1;
        sum_d  = sum_q + DadoEntrada;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = SOMA;
      end
      SOMA: if (aceita) begin
        if (8'(sum_q + DadoEntrada) == 8'd0) begin
          pc_d    = base_q;
          rcpu_d  = 1'b1;
          state_d = EXECUTA;
        end else begin
          erro_d  = 1'b1;
          state_d = OCIOSO;
        end
      end
      EXECUTA: if (Instrucao == HALT_OPCODE) begin
        parado_d = 1'b1;
        rcpu_d   = 1'b0;
        state_d  = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
    pronta_d = state_d != EXECUTA;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      base_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      idle_q   <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rcpu_q   <= 1'b0;
      pc_q     <= '0;
      parado_q <= 1'b0;
      erro_q   <= 1'b0;
      pronta_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      sum_q    <= sum_d;
      idle_q   <= idle_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rcpu_q   <= rcpu_d;
      pc_q     <= pc_d;
      parado_q <= parado_d;
      erro_q   <= erro_d;
      pronta_q <= pronta_d;
    end
  end

  assign EntradaPronta = pronta_q;
  assign EscreverInstr = wr_q;
  assign EnderecoInstr = addr_q;
  assign DadoInstr     = data_q;
  assign ResetCPU      = rcpu_q;
  assign PCInicial     = pc_q;
  assign Parado        = parado_q;
  assign Erro          = erro_q;
endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: scoreboard bench; a frame model predicts memory writes and load outcome.
module tb_carregador_programa;
  logic       clock = 1'b0, reset = 1'b0;
  logic [7:0] DadoEntrada = 8'h00, Instrucao = 8'h00;
  logic       EntradaValida = 1'b0;
  logic       EntradaPronta, EscreverInstr, ResetCPU, Parado, Erro;
  logic [7:0] EnderecoInstr, DadoInstr, PCInicial;

  carregador_programa dut (
    .clock(clock), .reset(reset), .DadoEntrada(DadoEntrada), .EntradaValida(EntradaValida),
    .EntradaPronta(EntradaPronta), .EscreverInstr(EscreverInstr), .EnderecoInstr(EnderecoInstr),
    .DadoInstr(DadoInstr), .ResetCPU(ResetCPU), .PCInicial(PCInicial), .Instrucao(Instrucao),
    .Parado(Parado), .Erro(Erro)
  );

  always #5 clock = ~clock;

  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];
  int  n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // write monitor: every strobe must match the oldest predicted write
  always @(negedge clock) begin
    if (EscreverInstr !== 1'b0) begin
      wr_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h strobe %b, none expected", EnderecoInstr, DadoInstr, EscreverInstr);
      end else begin
        e = exp_q.pop_front();
        if (EnderecoInstr !== e.a || DadoInstr !== e.d) begin
          n_fail++;
          $display("FAIL write: got %0h/%0h expected %0h/%0h", EnderecoInstr, DadoInstr, e.a, e.d);
        end
      end
    end
  end

  function automatic bit frame_ok(input logic [7:0] f[$]);
    logic [7:0] s = 8'h00;
    if (f[1] == 8'h00) return 1'b0;
    for (int i = 0; i <= int'(f[1]); i++) s = s + f[2 + i];
    return s == 8'h00;
  endfunction

  task automatic send(input logic [7:0] b);
    int w = 0;
    @(negedge clock);
    while (EntradaPronta !== 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (w >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_wait: EntradaPronta %b after 50 cycles, required 1", EntradaPronta);
    end
    DadoEntrada   = b;
    EntradaValida = 1'b1;
    @(posedge clock);
    #1 EntradaValida = 1'b0;
  endtask

  // predicts writes for whatever payload bytes are present, then streams the frame
  task automatic send_frame(input logic [7:0] f[$], input int gap);
    int len = (f.size() > 1) ? int'(f[1]) : 0;
    for (int i = 2; i < f.size() && i < 2 + len; i++) begin
      wr_t e;
      e.a = f[0] + 8'(i - 2);
      e.d = f[i];
      exp_q.push_back(e);
    end
    for (int i = 0; i < f.size(); i++) begin
      send(f[i]);
      if (i == 0) begin
        check("erro_cleared", {15'd0, Erro}, 16'd0);
        check("parado_cleared", {15'd0, Parado}, 16'd0);
      end
      if (i != f.size() - 1) repeat (gap) @(posedge clock);
    end
  endtask

  task automatic run_full(input logic [7:0] f[$], input int gap);
    bit ok = frame_ok(f);
    send_frame(f, gap);
    check("resetcpu_after_sum", {15'd0, ResetCPU}, {15'd0, ok});
    check("erro_after_frame", {15'd0, Erro}, {15'd0, !ok});
    check("pronta_after_frame", {15'd0, EntradaPronta}, {15'd0, !ok});
    if (ok) begin
      check("pc_inicial", {8'd0, PCInicial}, {8'd0, f[0]});
      repeat ($urandom_range(1, 4)) begin
        @(negedge clock);
        Instrucao = 8'($urandom_range(0, 191));
      end
      @(negedge clock);
      check("running", {14'd0, ResetCPU, EntradaPronta}, 16'b10);
      Instrucao = 8'hC0;
      @(posedge clock);
      #1;
      check("halt_parado", {15'd0, Parado}, 16'd1);
      check("halt_resetcpu", {15'd0, ResetCPU}, 16'd0);
      check("halt_pronta", {15'd0, EntradaPronta}, 16'd1);
      check("pc_holds", {8'd0, PCInicial}, {8'd0, f[0]});
      Instrucao = 8'h00;
    end
    repeat (2) @(posedge clock);
    #1 check("writes_drained", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] s;
    #1;
    check("rst_outputs", {EntradaPronta, EscreverInstr, ResetCPU, Parado, Erro, EnderecoInstr, 3'b0}, 16'd0);
    check("rst_dado_pc", {DadoInstr, PCInicial}, 16'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    f = '{8'h14, 8'h03, 8'hE0, 8'h0F, 8'hC0, 8'h51};
    run_full(f, 0);
    f = '{8'h14, 8'h03, 8'hE0, 8'h0F, 8'hC0, 8'h50};
    run_full(f, 0);
    f = '{8'h14, 8'h03, 8'hE0, 8'h0F, 8'hC0, 8'h51};
    run_full(f, 0);
    f = '{8'h05, 8'h00};
    run_full(f, 0);
    f = '{8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    run_full(f, 0);

    f = '{8'h14, 8'h02, 8'hAA};
    send_frame(f, 0);
    repeat (254) @(posedge clock);
    @(negedge clock);
    check("timeout_not_yet", {15'd0, Erro}, 16'd0);
    @(posedge clock);
    #1 check("timeout_erro", {15'd0, Erro}, 16'd1);
    repeat (3) @(posedge clock);
    #1 check("timeout_one_write", 16'(exp_q.size()), 16'd0);

    f = '{8'h40, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
    run_full(f, 1);

    for (int t = 0; t < 14; t++) begin
      int len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      f = {};
      s = 8'h00;
      f.push_back(8'($urandom));
      f.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
        f.push_back(8'($urandom));
        s = s + f[2 + i];
      end
      if (len != 0) f.push_back(($urandom_range(0, 3) == 0) ? 8'(-s) + 8'($urandom_range(1, 255)) : 8'(-s));
      run_full(f, $urandom_range(0, 3));
    end

    f = '{8'h30, 8'h05, 8'h11, 8'h22};
    send_frame(f, 0);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("async_rst_outputs", {EntradaPronta, EscreverInstr, ResetCPU, Parado, Erro, EnderecoInstr, 3'b0}, 16'd0);
    check("async_rst_dado_pc", {DadoInstr, PCInicial}, 16'd0);
    #1 reset = 1'b1;
    repeat (6) @(posedge clock);
    #1 check("no_write_after_rst", 16'(exp_q.size()), 16'd0);
    check("idle_after_rst", {14'd0, EntradaPronta, Erro}, 16'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
